instr_loader: RTL

//  Writer side of instruction memory: receives a byte stream, assembles big-endian 32-bit instructions and writes them to imem.

---
 rtl/instr_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// Purpose: assembles a big-endian byte stream into 32-bit instructions, screens opcodes, writes imem, holds the core until loaded.
// Latency: 4th byte accepted at edge N -> imem write strobe during cycle N..N+1 -> done/error visible after edge N+1.
// Backpressure: in_ready is high only while receiving; it drops for the single write cycle, giving at most one word per 5 cycles.
module instr_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_write_en,
   output logic [31:0]       imem_write_addr,
   output logic [31:0]       imem_write_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [5:0]        bad_opcode,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   // Largest legal program: the whole imem.
   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W+1)'(1);

   // Opcodes the core's control decoder understands.
   function automatic logic opcode_ok(input logic [5:0] op);
      case (op)
         6'h00, 6'h23, 6'h2B, 6'h04: opcode_ok = 1'b1;
         default:                    opcode_ok = 1'b0;
      endcase
   endfunction

   state_t            state_q, state_nxt;
   logic [31:0]       shift_q, shift_nxt;
   logic [1:0]        byte_idx_q, byte_idx_nxt;
   logic [ADDR_W:0]   count_q, count_nxt;

   logic              wen_nxt;
   logic [31:0]       addr_nxt;
   logic [31:0]       data_nxt;
   logic              hold_nxt;
   logic              done_nxt;
   logic              error_nxt;
   logic [5:0]        bad_nxt;
   logic [ADDR_W:0]   loaded_nxt;

   logic [31:0]       assembled;
   logic              byte_take;

   // The only combinational output: ready exactly while collecting bytes.
   assign in_ready  = (state_q == S_RECV);
   assign byte_take = in_ready && in_valid;
   // Word as it will look once the current byte is shifted in (MSB first).
   assign assembled = {shift_q[23:0], in_byte};

   // State register and all registered outputs; reset drops any partial word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         shift_q         <= '0;
         byte_idx_q      <= '0;
         count_q         <= '0;
         imem_write_en   <= 1'b0;
         imem_write_addr <= '0;
         imem_write_data <= '0;
         cpu_hold        <= 1'b1;
         done            <= 1'b0;
         error           <= 1'b0;
         bad_opcode      <= '0;
         words_loaded    <= '0;
      end else begin
         state_q         <= state_nxt;
         shift_q         <= shift_nxt;
         byte_idx_q      <= byte_idx_nxt;
         count_q         <= count_nxt;
         imem_write_en   <= wen_nxt;
         imem_write_addr <= addr_nxt;
         imem_write_data <= data_nxt;
         cpu_hold        <= hold_nxt;
         done            <= done_nxt;
         error           <= error_nxt;
         bad_opcode      <= bad_nxt;
         words_loaded    <= loaded_nxt;
      end
   end

   // Next-state and next-output decode; everything holds unless a state says otherwise.
   always_comb begin
      state_nxt    = state_q;
      shift_nxt    = shift_q;
      byte_idx_nxt = byte_idx_q;
      count_nxt    = count_q;
      wen_nxt      = 1'b0;
      addr_nxt     = imem_write_addr;
      data_nxt     = imem_write_data;
      hold_nxt     = cpu_hold;
      done_nxt     = done;
      error_nxt    = error;
      bad_nxt      = bad_opcode;
      loaded_nxt   = words_loaded;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               done_nxt     = 1'b0;
               error_nxt    = 1'b0;
               bad_nxt      = '0;
               loaded_nxt   = '0;
               byte_idx_nxt = '0;
               hold_nxt     = 1'b1;
               count_nxt    = word_count;
               if (word_count == '0) begin
                  // Empty program: release the core straight away.
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
                  hold_nxt  = 1'b0;
               end else if (word_count > MAX_WORDS) begin
                  // Program cannot fit; opcode field reads 0 to mark a size fault.
                  state_nxt = S_ERR;
                  error_nxt = 1'b1;
               end else begin
                  state_nxt = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (byte_take) begin
               shift_nxt    = assembled;
               byte_idx_nxt = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_nxt = S_WRITE;
                  // Strobe is registered, so it is launched here to be visible during WRITE.
                  if (opcode_ok(assembled[31:26])) begin
                     wen_nxt    = 1'b1;
                     addr_nxt   = {{(32-ADDR_W-3){1'b0}}, words_loaded, 2'b00};
                     data_nxt   = assembled;
                     loaded_nxt = words_loaded + ONE_WORD;
                  end
               end
            end
         end

         S_WRITE: begin
            // words_loaded already counts the word being written this cycle.
            if (opcode_ok(shift_q[31:26])) begin
               if (words_loaded == count_q) begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
                  hold_nxt  = 1'b0;
               end else begin
                  state_nxt = S_RECV;
               end
            end else begin
               state_nxt = S_ERR;
               error_nxt = 1'b1;
               bad_nxt   = shift_q[31:26];
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
